// File: rtl/de0_7_segment_counter.sv
// Multi-digit hex/BCD up/down counter with prescaled step and an active-low
// 7-segment encoder (one byte per digit), meant to drive DE0 HEX pins directly.
module de0_7_segment_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 12500000,
    parameter int PS_W     = 32,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk_50,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  up,
    input  logic                  bcd,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap,
    output logic [8*DIGITS-1:0]   hex
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]       ps_reg;
    logic [PS_W-1:0]       ps_next;
    logic                  tick_reg;
    logic [4*DIGITS-1:0]   count_reg;
    logic [4*DIGITS-1:0]   count_next;
    logic                  wrap_reg;
    logic                  wrap_next;
    logic [8*DIGITS-1:0]   hex_reg;
    logic [8*DIGITS-1:0]   hex_next;
    logic [8*DIGITS-1:0]   hex_rst;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // Load restarts the prescaler so the next step comes a full period later.
    always_comb begin
        ps_next = ps_reg + PS_W'(1);
        if (load || ps_reg == PS_LAST) begin
            ps_next = '0;
        end
    end

    // Ripple carry/borrow from digit 0; cy left set past the top digit means wrap.
    always_comb begin
        logic       cy;
        logic [3:0] lim;
        logic [3:0] dig;
        cy         = 1'b1;
        lim        = bcd ? 4'd9 : 4'd15;
        dig        = '0;
        count_next = count_reg;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_reg[4*i +: 4];
            if (cy) begin
                if (up) begin
                    if (dig >= lim) begin
                        count_next[4*i +: 4] = 4'd0;
                    end else begin
                        count_next[4*i +: 4] = dig + 4'd1;
                        cy = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        count_next[4*i +: 4] = lim;
                    end else if (dig > lim) begin
                        count_next[4*i +: 4] = lim;
                        cy = 1'b0;
                    end else begin
                        count_next[4*i +: 4] = dig - 4'd1;
                        cy = 1'b0;
                    end
                end
            end
        end
        wrap_next = cy;
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0 || BLANK_LZ == 0) begin : g_plain
                assign hex_next[8*gi +: 8] = glyph(count_reg[4*gi +: 4]);
                assign hex_rst[8*gi +: 8]  = 8'hC0;
            end else begin : g_blank
                // Blank when this digit and all digits above it are zero.
                assign hex_next[8*gi +: 8] = (count_reg[4*DIGITS-1:4*gi] == '0)
                                             ? 8'hFF : glyph(count_reg[4*gi +: 4]);
                assign hex_rst[8*gi +: 8]  = 8'hFF;
            end
        end
    endgenerate

    always_ff @(posedge clk_50) begin
        if (rst) begin
            ps_reg    <= '0;
            tick_reg  <= 1'b0;
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            hex_reg   <= hex_rst;
        end else begin
            ps_reg   <= ps_next;
            tick_reg <= (ps_next == PS_LAST);
            hex_reg  <= hex_next;
            if (load) begin
                count_reg <= load_value;
                wrap_reg  <= 1'b0;
            end else if (tick_reg && run) begin
                count_reg <= count_next;
                wrap_reg  <= wrap_next;
            end else begin
                wrap_reg  <= 1'b0;
            end
        end
    end

    assign count = count_reg;
    assign tick  = tick_reg;
    assign wrap  = wrap_reg;
    assign hex   = hex_reg;

endmodule

// File: tb/tb_de0_7_segment_counter.sv
// Bench for de0_7_segment_counter: directed scenarios plus random stimulus,
// checked every cycle against a digit-list reference model (plain and blanked variants).
module tb_de0_7_segment_counter;

    localparam int D  = 4;
    localparam int PS = 4;

    logic          clk_50 = 1'b0;
    logic          rst = 1'b1, run = 1'b0, up = 1'b1, bcd = 1'b0, load = 1'b0;
    logic [15:0]   lv = '0;
    logic [15:0]   count0, count1;
    logic          tick0, tick1, wrap0, wrap1;
    logic [31:0]   hex0, hex1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ps;
    bit          m_tick, m_wrap;
    int          m_dig [D];
    logic [31:0] m_hex0, m_hex1;

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk_50 = ~clk_50;

    de0_7_segment_counter #(.DIGITS(D), .PRESCALE(PS), .PS_W(8), .BLANK_LZ(0)) dut0 (
        .clk_50(clk_50), .rst(rst), .run(run), .up(up), .bcd(bcd), .load(load),
        .load_value(lv), .count(count0), .tick(tick0), .wrap(wrap0), .hex(hex0));

    de0_7_segment_counter #(.DIGITS(D), .PRESCALE(PS), .PS_W(8), .BLANK_LZ(1)) dut1 (
        .clk_50(clk_50), .rst(rst), .run(run), .up(up), .bcd(bcd), .load(load),
        .load_value(lv), .count(count1), .tick(tick1), .wrap(wrap1), .hex(hex1));

    function automatic logic [15:0] m_count();
        logic [15:0] v = '0;
        for (int n = 0; n < D; n++) v[4*n +: 4] = 4'(m_dig[n]);
        return v;
    endfunction

    function automatic logic [31:0] encode(input bit blank_lz);
        logic [31:0] h = '0;
        for (int n = 0; n < D; n++) begin
            bit all_zero = 1'b1;
            for (int k = n; k < D; k++) if (m_dig[k] != 0) all_zero = 1'b0;
            h[8*n +: 8] = (blank_lz && n > 0 && all_zero) ? 8'hFF : glyph_tab[m_dig[n]];
        end
        return h;
    endfunction

    // One count step on the digit list; returns 1 when the carry/borrow runs off the top.
    function automatic bit model_step(input bit dir_up, input bit dec);
        int lim = dec ? 9 : 15;
        int i = 0;
        if (dir_up) begin
            while (i < D && m_dig[i] >= lim) begin m_dig[i] = 0; i++; end
            if (i == D) return 1'b1;
            m_dig[i] = m_dig[i] + 1;
        end else begin
            while (i < D && m_dig[i] == 0) begin m_dig[i] = lim; i++; end
            if (i == D) return 1'b1;
            m_dig[i] = (m_dig[i] > lim) ? lim : m_dig[i] - 1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ps = 0; m_tick = 0; m_wrap = 0;
            for (int n = 0; n < D; n++) m_dig[n] = 0;
            m_hex0 = encode(0); m_hex1 = encode(1);
        end else begin
            m_hex0 = encode(0); m_hex1 = encode(1);
            if (load) begin
                for (int n = 0; n < D; n++) m_dig[n] = int'(lv[4*n +: 4]);
                m_ps = 0; m_wrap = 0;
            end else begin
                m_wrap = (m_tick && run) ? model_step(up, bcd) : 1'b0;
                m_ps = (m_ps + 1) % PS;
            end
            m_tick = (m_ps == PS - 1);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_50);
        model_edge();
        @(negedge clk_50);
        check("count",    32'(count0), 32'(m_count()));
        check("count_bl", 32'(count1), 32'(m_count()));
        check("tick",     32'(tick0),  32'(m_tick));
        check("tick_bl",  32'(tick1),  32'(m_tick));
        check("wrap",     32'(wrap0),  32'(m_wrap));
        check("wrap_bl",  32'(wrap1),  32'(m_wrap));
        check("hex",      hex0, m_hex0);
        check("hex_bl",   hex1, m_hex1);
        $display("cyc t=%0t rst=%b ld=%b run=%b up=%b bcd=%b lv=%h count=%h tick=%b wrap=%b hex=%h hexbl=%h",
                 $time, rst, load, run, up, bcd, lv, count0, tick0, wrap0, hex0, hex1);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; lv = v;
        cycle();
        load = 1'b0;
    endtask

    // Advance until the model's tick is up, then take the stepping edge.
    task automatic wait_step();
        int n = 0;
        while (!m_tick && n < 16) begin cycle(); n++; end
        if (!m_tick) begin
            checks++; errors++;
            $display("FAIL step_timeout: actual=no_tick required=tick within 16 cycles");
        end
        cycle();
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] picks [6] = '{16'h0FFF, 16'hFFFF, 16'h0999, 16'h0000, 16'h000C, 16'h9999};

        // 1. reset, then free-running hex count
        rst = 1'b1; cycle(); cycle();
        check("rst_count", 32'(count0), 32'h0);
        check("rst_hex",   hex0, 32'hC0C0C0C0);
        check("rst_hexbl", hex1, 32'hFFFFFFC0);
        check("rst_tick",  32'(tick0), 32'h0);
        rst = 1'b0; run = 1'b1; up = 1'b1; bcd = 1'b0;
        repeat (4) cycle();
        check("first_step", 32'(count0), 32'h0001);
        check("hex_lag",    32'(hex0[7:0]), 32'hC0);
        cycle();
        check("hex_after",  32'(hex0[7:0]), 32'hF9);
        repeat (10) cycle();

        // 2. hex carry and wrap
        do_load(16'h0FFF); wait_step();
        check("hex_carry", 32'(count0), 32'h1000);
        do_load(16'hFFFF); wait_step();
        check("hex_wrap_cnt", 32'(count0), 32'h0000);
        check("hex_wrap",     32'(wrap0), 32'h1);
        cycle();
        check("wrap_1cyc",    32'(wrap0), 32'h0);

        // 3. BCD carry and down wrap
        bcd = 1'b1;
        do_load(16'h0999); wait_step();
        check("bcd_carry", 32'(count0), 32'h1000);
        up = 1'b0;
        do_load(16'h0000); wait_step();
        check("bcd_down_wrap", 32'(count0), 32'h9999);
        check("bcd_wrap",      32'(wrap0), 32'h1);

        // 4. illegal BCD digit handling
        up = 1'b1;
        do_load(16'h000C); wait_step();
        check("bcd_ill_up", 32'(count0), 32'h0010);
        up = 1'b0;
        do_load(16'h000C); wait_step();
        check("bcd_ill_dn", 32'(count0), 32'h0009);
        check("bcd_ill_wrap", 32'(wrap0), 32'h0);

        // 5. pause, then load coincident with tick
        run = 1'b0; held = count0;
        repeat (20) cycle();
        check("pause_hold", 32'(count0), 32'(held));
        run = 1'b1; up = 1'b1; bcd = 1'b0;
        begin
            int n = 0;
            while (!m_tick && n < 8) begin cycle(); n++; end
        end
        do_load(16'h1234);
        check("load_on_tick", 32'(count0), 32'h1234);
        repeat (3) cycle();
        check("tick_after_load", 32'(tick0), 32'h1);

        // 6. blanking and mid-count reset
        run = 1'b0;
        do_load(16'h0050); cycle();
        check("blank_hex", hex1, 32'hFFFF92C0);
        run = 1'b1;
        repeat (6) cycle();
        rst = 1'b1; cycle();
        check("rst_mid_count", 32'(count1), 32'h0);
        check("rst_mid_tick",  32'(tick1), 32'h0);
        rst = 1'b0; cycle();
        check("rst_mid_hex", hex1, 32'hFFFFFFC0);

        // Random phase
        for (int i = 0; i < 2500; i++) begin
            rst  = ($urandom_range(199) == 0);
            load = ($urandom_range(15) == 0);
            lv   = ($urandom_range(1) == 0) ? picks[$urandom_range(5)] : 16'($urandom);
            run  = ($urandom_range(7) != 0);
            up   = 1'($urandom);
            bcd  = 1'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
